// File: rtl/psum_acc_pkg.sv
// Shared types and helpers for the partial-sum accumulator engine.
// Saturation works on a 32-bit signed carrier; callers truncate to width.
package psum_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int SAT_W = 32;

    function automatic logic signed [SAT_W-1:0] sat_s(
        input logic signed [SAT_W-1:0] v,
        input int                      w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = $signed((32'd1 << (w - 1)) - 32'd1);
        lo = -hi - 32'sd1;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    function automatic int lane_lsb(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/psum_post_lane.sv
// One lane of the drain post stage: arithmetic shift, optional ReLU,
// then saturation to the output lane width.
module psum_post_lane
    import psum_acc_pkg::*;
#(
    parameter int ACC_BW  = 20,
    parameter int PSUM_BW = 16
) (
    input  logic signed [ACC_BW-1:0]  acc,
    input  logic        [3:0]         shift,
    input  logic                      relu,
    output logic signed [PSUM_BW-1:0] y
);

    logic signed [ACC_BW-1:0] sh;
    logic signed [SAT_W-1:0]  wide;

    always_comb begin
        sh = acc >>> shift;
        if (relu && sh[ACC_BW-1]) begin
            sh = '0;
        end
        wide = {{(SAT_W - ACC_BW){sh[ACC_BW-1]}}, sh};
        y    = PSUM_BW'(sat_s(wide, PSUM_BW));
    end

endmodule

// File: rtl/psum_acc_engine.sv
// Multi-pass partial-sum accumulator with a flop-array buffer,
// post stage and valid/ready handshakes on both sides.
module psum_acc_engine
    import psum_acc_pkg::*;
#(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int ACC_BW  = 20,
    parameter int DEPTH   = 16,
    parameter int PASS_W  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_start,
    input  logic [$clog2(DEPTH):0]    cfg_len,
    input  logic [PASS_W-1:0]         cfg_passes,
    input  logic                      cfg_relu,
    input  logic [3:0]                cfg_shift,
    output logic                      busy,
    output logic                      done,
    output logic                      cfg_err,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [COL*PSUM_BW-1:0]    in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [COL*PSUM_BW-1:0]    out_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    state_t state_q, state_d;

    logic [LW-1:0]     len_q;
    logic [PASS_W-1:0] passes_q;
    logic              relu_q;
    logic [3:0]        shift_q;
    logic [AW-1:0]     wr_addr_q;
    logic [PASS_W-1:0] pass_q;
    logic [LW-1:0]     rd_cnt_q;
    logic [LW-1:0]     out_cnt_q;
    logic              arm_q;
    logic              out_valid_q;
    logic [COL*PSUM_BW-1:0] out_data_q;
    logic              done_q;
    logic              err_q;

    logic signed [ACC_BW-1:0] acc_mem [DEPTH][COL];
    logic signed [ACC_BW-1:0] wsum [COL];
    logic signed [SAT_W-1:0]  ext_in;
    logic signed [SAT_W-1:0]  ext_acc;
    logic [COL*PSUM_BW-1:0]   post_vec;
    logic [AW-1:0]            rd_addr;

    logic cfg_ok;
    logic in_fire;
    logic wr_last;
    logic pass_last;
    logic out_fire;
    logic out_last;
    logic load;

    assign cfg_ok = (cfg_len != '0) && (cfg_len <= LW'(DEPTH))
                 && (cfg_passes != '0);
    assign in_fire   = in_valid && (state_q == ACC);
    assign wr_last   = {1'b0, wr_addr_q} == (len_q - LW'(1));
    assign pass_last = pass_q == (passes_q - PASS_W'(1));
    assign out_fire  = out_valid_q && out_ready;
    assign out_last  = out_cnt_q == (len_q - LW'(1));
    assign rd_addr   = rd_cnt_q[AW-1:0];
    // arm_q delays the first read by one cycle after entering DRAIN
    assign load = (state_q == DRAIN) && arm_q && (rd_cnt_q < len_q)
               && (!out_valid_q || out_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cfg_start && cfg_ok) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                if (in_fire && wr_last && pass_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire && out_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = state_q != IDLE;
        in_ready = state_q == ACC;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q       <= '0;
            passes_q    <= '0;
            relu_q      <= 1'b0;
            shift_q     <= '0;
            wr_addr_q   <= '0;
            pass_q      <= '0;
            rd_cnt_q    <= '0;
            out_cnt_q   <= '0;
            arm_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= (state_q == DRAIN) && out_fire && out_last;
            err_q  <= (state_q == IDLE) && cfg_start && !cfg_ok;
            arm_q  <= state_q == DRAIN;
            if ((state_q == IDLE) && cfg_start && cfg_ok) begin
                len_q     <= cfg_len;
                passes_q  <= cfg_passes;
                relu_q    <= cfg_relu;
                shift_q   <= cfg_shift;
                wr_addr_q <= '0;
                pass_q    <= '0;
                rd_cnt_q  <= '0;
                out_cnt_q <= '0;
            end
            if (in_fire) begin
                if (wr_last) begin
                    wr_addr_q <= '0;
                    pass_q    <= pass_q + PASS_W'(1);
                end else begin
                    wr_addr_q <= wr_addr_q + AW'(1);
                end
            end
            if (load) begin
                rd_cnt_q    <= rd_cnt_q + LW'(1);
                out_valid_q <= 1'b1;
                out_data_q  <= post_vec;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end
            if (out_fire) begin
                out_cnt_q <= out_cnt_q + LW'(1);
            end
        end
    end

    // Pass 0 overwrites, so stale contents after reset never leak out
    always_comb begin
        wsum    = '{default: '0};
        ext_in  = '0;
        ext_acc = '0;
        for (int c = 0; c < COL; c++) begin
            ext_in = {{(SAT_W - PSUM_BW){
                         in_data[lane_lsb(c, PSUM_BW) + PSUM_BW - 1]}},
                      in_data[lane_lsb(c, PSUM_BW) +: PSUM_BW]};
            ext_acc = {{(SAT_W - ACC_BW){acc_mem[wr_addr_q][c][ACC_BW-1]}},
                       acc_mem[wr_addr_q][c]};
            if (pass_q == '0) begin
                wsum[c] = ACC_BW'(ext_in);
            end else begin
                wsum[c] = ACC_BW'(sat_s(ext_acc + ext_in, ACC_BW));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int c = 0; c < COL; c++) begin
                acc_mem[wr_addr_q][c] <= wsum[c];
            end
        end
    end

    for (genvar g = 0; g < COL; g++) begin : g_post
        psum_post_lane #(
            .ACC_BW (ACC_BW),
            .PSUM_BW(PSUM_BW)
        ) u_lane (
            .acc  (acc_mem[rd_addr][g]),
            .shift(shift_q),
            .relu (relu_q),
            .y    (post_vec[g*PSUM_BW +: PSUM_BW])
        );
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign done      = done_q;
    assign cfg_err   = err_q;

endmodule
